apb_perf_cnt_slave: RTL and testbench

APB_PERF_CNT_SLAVE -- requirements
Module: apb_perf_cnt_slave

---
 rtl/apb_perf_cnt_slave_if.sv | 15 +
 rtl/apb_perf_cnt_slave.sv | 90 +++++++++
 tb/tb_apb_perf_cnt_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_perf_cnt_slave_if.sv
// apb_perf_cnt_slave_if: APB requester/completer signal bundle for the perf counter slave
interface apb_perf_cnt_slave_if #(
   parameter int ADR_W = 32
);
   logic [ADR_W-1:0] PADDR;
   logic             PSEL;
   logic             PENABLE;
   logic             PWRITE;
   logic [31:0]      PWDATA;
   logic             PREADY;
   logic [31:0]      PRDATA;
   logic             PSLVERR;
   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PREADY, PRDATA, PSLVERR);
   modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_perf_cnt_slave.sv
// apb_perf_cnt_slave: APB-mapped bank of event counters with sticky overflow flags and interrupt
module apb_perf_cnt_slave #(
   parameter int                ADR_W    = 32,
   parameter logic [ADR_W-21:0] BASE_ADR = '0,
   parameter int                NUM_CH   = 8,
   parameter int                CNT_W    = 32,
   parameter int                WAIT_CYC = 0
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_perf_cnt_slave_if.slave apb,
   input  logic [NUM_CH-1:0]   ev_inc,
   output logic                irq
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   logic [0:0]        r_state;
   logic [2:0]        r_wcnt;
   logic              r_en, r_frz, r_irq;
   logic [NUM_CH-1:0] r_ovf, r_ie;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [17:0]       w_idx;
   logic              w_err, w_ready, w_wr, w_clr;
   logic [NUM_CH-1:0] w_hit, w_inc, w_set, w_w1c;
   logic [31:0]       w_rd;
   logic              w_unused_ok;
   assign w_idx       = apb.PADDR[19:2];
   assign w_err       = (apb.PADDR[ADR_W-1:20] != BASE_ADR) || (w_idx > 18'(NUM_CH + 3));
   // Qualifying with WAIT keeps a stale ACCESS phase after reset from completing
   assign w_ready     = PRESETn && r_state == S_WAIT && apb.PSEL && apb.PENABLE && r_wcnt == 3'(WAIT_CYC);
   assign w_wr        = w_ready && apb.PWRITE && !w_err;
   assign w_clr       = w_wr && w_idx == 18'd0 && apb.PWDATA[0];
   assign w_w1c       = (w_wr && w_idx == 18'd1) ? apb.PWDATA[NUM_CH-1:0] : '0;
   assign apb.PREADY  = w_ready;
   assign apb.PSLVERR = w_ready && w_err;
   assign apb.PRDATA  = (w_ready && !w_err) ? w_rd : '0;
   assign irq         = r_irq;
   assign w_unused_ok = ^{apb.PADDR[1:0], apb.PWDATA};
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_hit[c] = w_wr && w_idx == 18'(c + 4);
      assign w_inc[c] = r_en && !r_frz && ev_inc[c];
      // Only a wrap that actually lands raises the flag; CLR or a write steals it
      assign w_set[c] = w_inc[c] && !w_clr && !w_hit[c] && &r_cnt[c];
   end
   always_comb begin
      w_rd = w_idx == 18'd0 ? {29'd0, r_frz, r_en, 1'b0} :
             w_idx == 18'd1 ? 32'(r_ovf) :
             w_idx == 18'd2 ? 32'(r_ie) : '0;
      for (int i = 0; i < NUM_CH; i++)
         if (w_idx == 18'(i + 4)) w_rd = 32'(r_cnt[i]);
   end
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
      end else if (r_state == S_IDLE) begin
         if (apb.PSEL && !apb.PENABLE) begin
            r_state <= S_WAIT;
            r_wcnt  <= '0;
         end
      end else if (!apb.PSEL || w_ready) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
      end else if (apb.PENABLE) begin
         r_wcnt  <= r_wcnt + 3'd1;
      end
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         r_en  <= 1'b0;
         r_frz <= 1'b0;
         r_ie  <= '0;
         r_irq <= 1'b0;
      end else begin
         if (w_wr && w_idx == 18'd0) begin
            r_en  <= apb.PWDATA[1];
            r_frz <= apb.PWDATA[2];
         end
         if (w_wr && w_idx == 18'd2) r_ie <= apb.PWDATA[NUM_CH-1:0];
         r_irq <= |(r_ovf & r_ie);
      end
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            r_cnt[i] <= w_clr ? '0 : w_hit[i] ? apb.PWDATA[CNT_W-1:0] : w_inc[i] ? r_cnt[i] + CNT_W'(1) : r_cnt[i];
         r_ovf <= w_set | (r_ovf & ~w_w1c);
      end
endmodule

// File: tb/tb_apb_perf_cnt_slave.sv
// tb_apb_perf_cnt_slave: scenario tasks with a queue of expected {PSLVERR,PRDATA} per transfer
module tb_apb_perf_cnt_slave;
   localparam int          ADR_W    = 32;
   localparam int          NUM_CH   = 8;
   localparam int          CNT_W    = 8;
   localparam int          WAIT_CYC = 3;
   localparam logic [11:0] BASE     = 12'h0A5;
   logic              PCLK = 1'b0;
   logic              PRESETn = 1'b0;
   logic [NUM_CH-1:0] ev_inc = '0;
   logic              irq;
   int                checks = 0;
   int                errors = 0;
   logic [32:0]       sb [$];
   apb_perf_cnt_slave_if #(.ADR_W(ADR_W)) bus ();
   apb_perf_cnt_slave #(.ADR_W(ADR_W), .BASE_ADR(BASE), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAIT_CYC(WAIT_CYC)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus), .ev_inc(ev_inc), .irq(irq));
   always #5 PCLK = ~PCLK;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end
   function automatic logic [31:0] adr(input int idx, input logic bad);
      return {BASE ^ {11'd0, bad}, 18'(idx), 2'b00};
   endfunction
   // Entered and left at posedge+1; consecutive calls are back-to-back
   task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] rd, output logic er, output int cyc);
      bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = d; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      cyc = 0;
      forever begin
         @(negedge PCLK);
         cyc++;
         if (bus.PREADY || cyc >= 20) break;
         @(posedge PCLK); #1;
      end
      if (!bus.PREADY) begin
         checks++; errors++;
         $display("FAIL apb_timeout addr=%h got PREADY=0 required 1", a);
      end
      rd = bus.PRDATA; er = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd; logic er; int cyc;
      apb(a, 1'b1, d, rd, er, cyc);
   endtask
   task automatic pulse_at_ready(input int ch);
      int n = 0;
      while (!bus.PREADY && n < 40) begin @(negedge PCLK); n++; end
      if (!bus.PREADY) begin
         checks++; errors++;
         $display("FAIL pulse_timeout got PREADY=0 required 1");
      end
      ev_inc[ch] = 1'b1;
      @(posedge PCLK); #1;
      ev_inc[ch] = 1'b0;
   endtask
   task automatic test_reset;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PWDATA = '0; bus.PADDR = adr(0, 0);
      repeat (3) @(negedge PCLK);
      checks++;
      if ({bus.PREADY, bus.PSLVERR, bus.PRDATA} !== 34'd0) begin
         errors++; $display("FAIL reset_outputs got %h required 0", {bus.PREADY, bus.PSLVERR, bus.PRDATA});
      end
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; PRESETn = 1'b1;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b required 0", irq); end
      @(posedge PCLK); #1;
      for (int i = 0; i < 4 + NUM_CH; i++) begin
         sb.push_back(33'd0); apb(adr(i, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
         if ({er, rd} !== e) begin errors++; $display("FAIL reset_reg%0d got %h required %h", i, {er, rd}, e); end
      end
   endtask
   task automatic test_wait;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      sb.push_back(33'd0); apb(adr(0, 0), 1'b1, 32'h2, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e || cyc != 4) begin errors++; $display("FAIL wait_wr got %h cyc=%0d required %h cyc=4", {er, rd}, cyc, e); end
      sb.push_back({1'b0, 32'h2}); apb(adr(0, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e || cyc != 4) begin errors++; $display("FAIL wait_rd got %h cyc=%0d required %h cyc=4", {er, rd}, cyc, e); end
   endtask
   task automatic test_count;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      ev_inc[2] = 1'b1;
      repeat (5) @(posedge PCLK);
      #1 ev_inc[2] = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         sb.push_back({1'b0, (i == 2) ? 32'd5 : 32'd0}); apb(adr(4 + i, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
         if ({er, rd} !== e) begin errors++; $display("FAIL count_cnt%0d got %h required %h", i, {er, rd}, e); end
      end
   endtask
   task automatic test_ovf;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      wr(adr(4, 0), 32'hFF);
      wr(adr(2, 0), 32'h1);
      ev_inc[0] = 1'b1;
      @(posedge PCLK); #1;
      ev_inc[0] = 1'b0;
      @(negedge PCLK); checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b required 0", irq); end
      @(negedge PCLK); checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b required 1", irq); end
      @(posedge PCLK); #1;
      sb.push_back(33'd0); apb(adr(4, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL wrap_cnt0 got %h required %h", {er, rd}, e); end
      sb.push_back({1'b0, 32'h1}); apb(adr(1, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL wrap_ovf got %h required %h", {er, rd}, e); end
      wr(adr(1, 0), 32'h1);
      @(negedge PCLK); checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b required 1", irq); end
      @(negedge PCLK); checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
      @(posedge PCLK); #1;
      sb.push_back(33'd0); apb(adr(1, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL ovf_w1c got %h required %h", {er, rd}, e); end
      wr(adr(4, 0), 32'hFF);
      fork
         wr(adr(1, 0), 32'h1);
         pulse_at_ready(0);
      join
      sb.push_back({1'b0, 32'h1}); apb(adr(1, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL ovf_set_wins got %h required %h", {er, rd}, e); end
   endtask
   task automatic test_err;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      logic [31:0] a_tab [7];
      logic        w_tab [7];
      logic [32:0] x_tab [7];
      a_tab = '{adr(2, 1), adr(2, 1), adr(4 + NUM_CH, 0), adr(4 + NUM_CH, 0), adr(32'h3FFFF, 0), adr(2, 0), adr(3 + NUM_CH, 0)};
      w_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      x_tab = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h1}, {1'b0, 32'h0}};
      for (int i = 0; i < 7; i++) begin
         sb.push_back(x_tab[i]); apb(a_tab[i], w_tab[i], 32'hFF, rd, er, cyc); e = sb.pop_front(); checks++;
         if ({er, rd} !== e) begin errors++; $display("FAIL err_case%0d got %h required %h", i, {er, rd}, e); end
      end
      wr(adr(3, 0), 32'hFF);
      sb.push_back(33'd0); apb(adr(3, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL reserved got %h required %h", {er, rd}, e); end
   endtask
   task automatic test_clr;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      logic [31:0] a_tab [4];
      logic [32:0] x_tab [4];
      wr(adr(5, 0), 32'h33);
      fork
         wr(adr(0, 0), 32'h3);
         pulse_at_ready(1);
      join
      a_tab = '{adr(5, 0), adr(0, 0), adr(1, 0), adr(2, 0)};
      x_tab = '{{1'b0, 32'h0}, {1'b0, 32'h2}, {1'b0, 32'h1}, {1'b0, 32'h1}};
      for (int i = 0; i < 4; i++) begin
         sb.push_back(x_tab[i]); apb(a_tab[i], 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
         if ({er, rd} !== e) begin errors++; $display("FAIL clr_case%0d got %h required %h", i, {er, rd}, e); end
      end
      fork
         wr(adr(5, 0), 32'h10);
         pulse_at_ready(1);
      join
      sb.push_back({1'b0, 32'h10}); apb(adr(5, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL wr_beats_inc got %h required %h", {er, rd}, e); end
      wr(adr(0, 0), 32'h6);
      ev_inc[1] = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 ev_inc[1] = 1'b0;
      sb.push_back({1'b0, 32'h10}); apb(adr(5, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL frz_hold got %h required %h", {er, rd}, e); end
      wr(adr(0, 0), 32'h2);
      wr(adr(6, 0), 32'hFF);
      fork
         wr(adr(6, 0), 32'h1);
         pulse_at_ready(2);
      join
      sb.push_back({1'b0, 32'h1}); apb(adr(1, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL lost_inc_ovf got %h required %h", {er, rd}, e); end
   endtask
   task automatic test_back_to_back;
      logic [31:0] rd1, rd2; logic er1, er2; int cyc; logic [32:0] e; time t0;
      t0 = $time;
      sb.push_back({1'b0, 32'h5});
      sb.push_back({1'b0, 32'h22});
      wr(adr(2, 0), 32'h5);
      apb(adr(2, 0), 1'b0, 0, rd1, er1, cyc);
      wr(adr(7, 0), 32'h22);
      apb(adr(7, 0), 1'b0, 0, rd2, er2, cyc);
      checks++;
      if ($time - t0 != 200) begin errors++; $display("FAIL b2b_time got %0t required 200", $time - t0); end
      e = sb.pop_front(); checks++;
      if ({er1, rd1} !== e) begin errors++; $display("FAIL b2b_ie got %h required %h", {er1, rd1}, e); end
      e = sb.pop_front(); checks++;
      if ({er2, rd2} !== e) begin errors++; $display("FAIL b2b_cnt3 got %h required %h", {er2, rd2}, e); end
   endtask
   task automatic test_reset_mid;
      logic [31:0] rd; logic er; int cyc; logic [32:0] e;
      bus.PADDR = adr(2, 0); bus.PWRITE = 1'b1; bus.PWDATA = 32'hFF; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b0;
      #1 checks++;
      if ({bus.PREADY, bus.PSLVERR, bus.PRDATA, irq} !== 35'd0) begin
         errors++; $display("FAIL mid_reset_out got %h required 0", {bus.PREADY, bus.PSLVERR, bus.PRDATA, irq});
      end
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (2) begin
         @(negedge PCLK); checks++;
         if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL stale_access got PREADY=%b required 0", bus.PREADY); end
      end
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      for (int i = 0; i < 4 + NUM_CH; i++) begin
         sb.push_back(33'd0); apb(adr(i, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
         if ({er, rd} !== e) begin errors++; $display("FAIL mid_reg%0d got %h required %h", i, {er, rd}, e); end
      end
      sb.push_back(33'd0); apb(adr(2, 0), 1'b1, 32'h3, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e || cyc != 4) begin errors++; $display("FAIL fresh_wr got %h cyc=%0d required %h cyc=4", {er, rd}, cyc, e); end
      sb.push_back({1'b0, 32'h3}); apb(adr(2, 0), 1'b0, 0, rd, er, cyc); e = sb.pop_front(); checks++;
      if ({er, rd} !== e) begin errors++; $display("FAIL fresh_rd got %h required %h", {er, rd}, e); end
   endtask
   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
      test_reset;
      test_wait;
      test_count;
      test_ovf;
      test_err;
      test_clr;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
